// File: rtl/bus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Round-robin arbiter for the shared serial data bus. Grants one
//            master at a time, inserts a turnaround gap between owners and
//            revokes a grant that is held too long with no slave activity.
// Ports    : clk           - system clock, rising edge
//            rst           - asynchronous reset, active-high
//            mstr_req      - per-master level request
//            slave_busy    - shared slave-busy line, restarts the watchdog
//            mstr_grant    - registered one-hot grant
//            grant_id      - index of current or last owner
//            bus_util      - high exactly while a grant is active
//            timeout_pulse - one-cycle pulse when the watchdog revokes a grant
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
  parameter int NUM_MASTERS       = 4,
  parameter int ID_WIDTH          = 2,
  parameter int TIMEOUT_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES    = 200,
  parameter int TURNAROUND_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] mstr_req,
  input  logic                   slave_busy,
  output logic [NUM_MASTERS-1:0] mstr_grant,
  output logic [ID_WIDTH-1:0]    grant_id,
  output logic                   bus_util,
  output logic                   timeout_pulse
);

  localparam int                     c_tcnt_width = (TURNAROUND_CYCLES > 1) ? $clog2(TURNAROUND_CYCLES) : 1;
  localparam int                     c_cand_width = ID_WIDTH + 1;
  localparam logic [TIMEOUT_WIDTH-1:0] c_wdog_last = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [c_tcnt_width-1:0]  c_tcnt_last = c_tcnt_width'(TURNAROUND_CYCLES - 1);
  localparam logic [ID_WIDTH-1:0]      c_ptr_init  = ID_WIDTH'(NUM_MASTERS - 1);
  localparam logic [NUM_MASTERS-1:0]   c_one       = NUM_MASTERS'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_TURN = 2'd2
  } state_t;

  state_t                   r_state,   w_state_nxt;
  logic [ID_WIDTH-1:0]      r_ptr,     w_ptr_nxt;
  logic [NUM_MASTERS-1:0]   r_grant,   w_grant_nxt;
  logic [ID_WIDTH-1:0]      r_id,      w_id_nxt;
  logic                     r_util,    w_util_nxt;
  logic                     r_pulse,   w_pulse_nxt;
  logic [TIMEOUT_WIDTH-1:0] r_wdog,    w_wdog_nxt;
  logic [c_tcnt_width-1:0]  r_tcnt,    w_tcnt_nxt;
  logic [NUM_MASTERS-1:0]   r_lockout, w_lockout_nxt;
  logic [NUM_MASTERS-1:0]   w_lock_set;
  logic [NUM_MASTERS-1:0]   w_eligible;
  logic [c_cand_width-1:0]  w_cand;
  logic [ID_WIDTH-1:0]      w_sel;
  logic                     w_found;

  assign w_eligible = mstr_req & ~r_lockout;

  // Round-robin pick: first eligible master strictly after the pointer,
  // wrapping modulo NUM_MASTERS. The extra candidate bit holds the sum
  // before the wrap subtraction.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      w_cand = {1'b0, r_ptr} + c_cand_width'(off);
      if (w_cand >= c_cand_width'(NUM_MASTERS)) begin
        w_cand = w_cand - c_cand_width'(NUM_MASTERS);
      end
      if (!w_found && w_eligible[w_cand[ID_WIDTH-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_cand[ID_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant;
    w_id_nxt    = r_id;
    w_util_nxt  = r_util;
    w_pulse_nxt = 1'b0;
    w_wdog_nxt  = r_wdog;
    w_tcnt_nxt  = r_tcnt;
    w_lock_set  = '0;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_nxt = c_one << w_sel;
          w_id_nxt    = w_sel;
          w_util_nxt  = 1'b1;
          w_wdog_nxt  = '0;
          w_state_nxt = S_OWN;
        end
      end
      S_OWN: begin
        // A request drop wins over a coincident timeout: normal release, no pulse.
        if (!mstr_req[r_id]) begin
          w_grant_nxt = '0;
          w_util_nxt  = 1'b0;
          w_ptr_nxt   = r_id;
          w_tcnt_nxt  = '0;
          w_state_nxt = S_TURN;
        end else if ((r_wdog == c_wdog_last) && !slave_busy) begin
          w_grant_nxt      = '0;
          w_util_nxt       = 1'b0;
          w_ptr_nxt        = r_id;
          w_tcnt_nxt       = '0;
          w_lock_set[r_id] = 1'b1;
          w_pulse_nxt      = 1'b1;
          w_state_nxt      = S_TURN;
        end else if (slave_busy) begin
          w_wdog_nxt = '0;
        end else begin
          w_wdog_nxt = r_wdog + TIMEOUT_WIDTH'(1);
        end
      end
      S_TURN: begin
        if (r_tcnt == c_tcnt_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_tcnt_nxt = r_tcnt + c_tcnt_width'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // A locked-out master is released as soon as it drops its request.
    w_lockout_nxt = (r_lockout | w_lock_set) & mstr_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= c_ptr_init;
      r_grant   <= '0;
      r_id      <= '0;
      r_util    <= 1'b0;
      r_pulse   <= 1'b0;
      r_wdog    <= '0;
      r_tcnt    <= '0;
      r_lockout <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_grant   <= w_grant_nxt;
      r_id      <= w_id_nxt;
      r_util    <= w_util_nxt;
      r_pulse   <= w_pulse_nxt;
      r_wdog    <= w_wdog_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_lockout <= w_lockout_nxt;
    end
  end

  assign mstr_grant    = r_grant;
  assign grant_id      = r_id;
  assign bus_util      = r_util;
  assign timeout_pulse = r_pulse;

endmodule
`default_nettype wire
